ppi_bus_sequencer: RTL

Bus master for the 8255-style PPI (`A[1:0]`, active-low CS/RD/WR, 8-bit data). After reset it writes a fixed mode control word to the PPI's control register. It then arbitrates two requesters round-robin, sequencing each port read or write into a timed SETUP/STROBE/HOLD bus cycle. It sits between system-side masters and the PPI top module and is the only driver of the PPI bus pins.

---
 rtl/ppi_bus_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ppi_bus_sequencer.sv
// rtl/ppi_bus_sequencer.sv - 8255 PPI bus master: init control-word write, round-robin SETUP/STROBE/HOLD cycles (option macro: PPI_SEQ_CTRL_ACCESS_EN)
module ppi_bus_sequencer #(
    parameter logic [7:0] CTRL_WORD     = 8'h9B,
    parameter int         STROBE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [1:0]  REQ,
    input  logic [1:0]  REQ_WE,
    input  logic [3:0]  REQ_ADDR,
    input  logic [15:0] REQ_WDATA,
    output logic [1:0]  GNT,
    output logic [1:0]  DONE,
    output logic [1:0]  ERR,
    output logic [7:0]  RDATA,
    output logic        INIT_DONE,
    output logic [1:0]  PPI_A,
    output logic        PPI_CS_N,
    output logic        PPI_RD_N,
    output logic        PPI_WR_N,
    output logic [7:0]  PPI_DOUT,
    output logic        PPI_DOE,
    input  logic [7:0]  PPI_DIN
);

`ifdef PPI_SEQ_CTRL_ACCESS_EN
    localparam bit CTRL_ACCESS_EN = 1'b1;
`else
    localparam bit CTRL_ACCESS_EN = 1'b0;
`endif

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_RESET, ST_INIT_SETUP, ST_INIT_STROBE, ST_INIT_HOLD,
        ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_REJECT
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [3:0]  strobeCnt;
    logic        strobeLast;
    logic        rrPtr;
    logic        latchId;
    logic        latchWe;
    logic [1:0]  latchAddr;
    logic [7:0]  latchWdata;
    logic [7:0]  rdataReg;
    logic        initDoneReg;

    logic        reqAny;
    logic        winner;
    logic        winWe;
    logic [1:0]  winAddr;
    logic [7:0]  winWdata;
    logic        winReject;
    logic [1:0]  idMask;

    // Arbitration: single requester wins outright, a tie goes to the RR pointer
    always_comb begin
        reqAny    = |REQ;
        winner    = (REQ == 2'b11) ? rrPtr : REQ[1];
        winWe     = REQ_WE[winner];
        winAddr   = winner ? REQ_ADDR[3:2] : REQ_ADDR[1:0];
        winWdata  = winner ? REQ_WDATA[15:8] : REQ_WDATA[7:0];
        winReject = (winAddr == 2'b11) && (!winWe || !CTRL_ACCESS_EN);
        strobeLast = (strobeCnt == STROBE_LAST);
        idMask    = latchId ? 2'b10 : 2'b01;
    end

    // State register; the pre-init state keeps the bus idle while reset is held
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_RESET;
        else          state <= nextState;
    end

    // Next-state sequencing
    always_comb begin
        nextState = state;
        case (state)
            ST_RESET:       nextState = ST_INIT_SETUP;
            ST_INIT_SETUP:  nextState = ST_INIT_STROBE;
            ST_INIT_STROBE: nextState = strobeLast ? ST_INIT_HOLD : ST_INIT_STROBE;
            ST_INIT_HOLD:   nextState = ST_IDLE;
            ST_IDLE:        nextState = !reqAny ? ST_IDLE : (winReject ? ST_REJECT : ST_SETUP);
            ST_SETUP:       nextState = ST_STROBE;
            ST_STROBE:      nextState = strobeLast ? ST_HOLD : ST_STROBE;
            ST_HOLD:        nextState = ST_IDLE;
            ST_REJECT:      nextState = ST_IDLE;
            default:        nextState = ST_RESET;
        endcase
    end

    // Strobe width counter, runs only while a strobe is asserted
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            strobeCnt <= 4'd0;
        end else if ((state == ST_STROBE || state == ST_INIT_STROBE) && !strobeLast) begin
            strobeCnt <= strobeCnt + 4'd1;
        end else begin
            strobeCnt <= 4'd0;
        end
    end

    // Latch the winner's operands at the grant edge and hand priority to the other side
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rrPtr      <= 1'b0;
            latchId    <= 1'b0;
            latchWe    <= 1'b0;
            latchAddr  <= 2'b00;
            latchWdata <= 8'h00;
        end else if (state == ST_IDLE && reqAny) begin
            rrPtr      <= ~winner;
            latchId    <= winner;
            latchWe    <= winWe;
            latchAddr  <= winAddr;
            latchWdata <= winWdata;
        end
    end

    // Read data capture on the edge leaving STROBE; init-done flag set leaving INIT_HOLD
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rdataReg    <= 8'h00;
            initDoneReg <= 1'b0;
        end else begin
            if (state == ST_STROBE && strobeLast && !latchWe) rdataReg <= PPI_DIN;
            if (state == ST_INIT_HOLD) initDoneReg <= 1'b1;
        end
    end

    // Bus pins and handshake pulses decoded from the current state
    always_comb begin
        GNT       = 2'b00;
        DONE      = 2'b00;
        ERR       = 2'b00;
        PPI_A     = latchAddr;
        PPI_CS_N  = 1'b1;
        PPI_RD_N  = 1'b1;
        PPI_WR_N  = 1'b1;
        PPI_DOUT  = latchWdata;
        PPI_DOE   = 1'b0;
        RDATA     = rdataReg;
        INIT_DONE = initDoneReg;
        case (state)
            ST_INIT_SETUP, ST_INIT_STROBE, ST_INIT_HOLD: begin
                PPI_A    = 2'b11;
                PPI_CS_N = 1'b0;
                PPI_DOUT = CTRL_WORD;
                PPI_DOE  = 1'b1;
                PPI_WR_N = (state != ST_INIT_STROBE);
            end
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                PPI_CS_N = 1'b0;
                PPI_DOE  = latchWe;
                if (state == ST_SETUP) GNT  = idMask;
                if (state == ST_HOLD)  DONE = idMask;
                if (state == ST_STROBE) begin
                    PPI_RD_N = latchWe;
                    PPI_WR_N = ~latchWe;
                end
            end
            ST_REJECT: begin
                GNT  = idMask;
                DONE = idMask;
                ERR  = idMask;
            end
            default: ;
        endcase
    end

endmodule
